// File: rtl/facelet_pkg.sv
// Shared types and constants for the face scan sequencer and its accumulator.
package facelet_pkg;

    localparam int FACELET_COUNT = 9;

    typedef logic [3:0] fac_idx_t;
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARM   = 3'd1;
    localparam state_t ST_ACCUM = 3'd2;
    localparam state_t ST_STORE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    function automatic int avg_shift(input int win);
        return 2 * $clog2(win);
    endfunction

    function automatic int sum_width(input int win);
        return 8 + avg_shift(win);
    endfunction

endpackage

// File: rtl/facelet_accum.sv
// Window compare plus RGB accumulators and pixel counter for one facelet window.
module facelet_accum
    import facelet_pkg::*;
#(
    parameter int WIN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       pix_valid,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] cube_x,
    input  logic [9:0] cube_y,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       full,
    output logic [7:0] avg_r,
    output logic [7:0] avg_g,
    output logic [7:0] avg_b
);

    localparam int SHIFT = avg_shift(WIN);
    localparam int SW    = sum_width(WIN);
    localparam int CW    = SHIFT + 1;
    localparam logic [CW-1:0] LAST = CW'(WIN * WIN - 1);
    localparam logic [10:0]   HALF = 11'(WIN / 2);

    logic [SW-1:0] sum_r, sum_g, sum_b;
    logic [CW-1:0] count;
    logic          in_x, in_y, take;

    // Widened to 11 bits so the window edges never wrap near the screen origin.
    assign in_x = ({1'b0, draw_x} + HALF >= {1'b0, cube_x}) && ({1'b0, draw_x} < {1'b0, cube_x} + HALF);
    assign in_y = ({1'b0, draw_y} + HALF >= {1'b0, cube_y}) && ({1'b0, draw_y} < {1'b0, cube_y} + HALF);
    assign take = en && pix_valid && in_x && in_y;
    assign full = take && !clear && (count == LAST);

    assign avg_r = sum_r[SW-1:SHIFT];
    assign avg_g = sum_g[SW-1:SHIFT];
    assign avg_b = sum_b[SW-1:SHIFT];

    // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
            count <= '0;
        end else if (clear) begin
            // A clear may coincide with the first pixel of a new attempt.
            sum_r <= take ? SW'(pix_r) : '0;
            sum_g <= take ? SW'(pix_g) : '0;
            sum_b <= take ? SW'(pix_b) : '0;
            count <= take ? CW'(1) : '0;
        end else if (take) begin
            sum_r <= sum_r + SW'(pix_r);
            sum_g <= sum_g + SW'(pix_g);
            sum_b <= sum_b + SW'(pix_b);
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/facelet_scan_ctrl.sv
// Scans the nine facelets of a cube face, one per frame, and stores their average colours.
// Optional FACELET_RETRY_LIMIT_EN bounds retries per facelet and raises a sticky err.
module facelet_scan_ctrl
    import facelet_pkg::*;
#(
    parameter int GRID_X0 = 220,
    parameter int GRID_Y0 = 140,
    parameter int PITCH   = 80,
    parameter int WIN     = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] Pix_R,
    input  logic [7:0] Pix_G,
    input  logic [7:0] Pix_B,
    output logic [9:0] CubeX,
    output logic [9:0] CubeY,
    output logic [9:0] CubeS,
    output logic [7:0] Color_R,
    output logic [7:0] Color_G,
    output logic [7:0] Color_B,
    output logic       fac_we,
    output logic [3:0] fac_idx,
    output logic [7:0] fac_R,
    output logic [7:0] fac_G,
    output logic [7:0] fac_B,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam fac_idx_t LAST_IDX = fac_idx_t'(FACELET_COUNT - 1);

    state_t   state, state_d;
    fac_idx_t idx;
    logic     abort, force_store, acc_clear, acc_en, acc_full, accepted;
    logic [7:0] avg_r, avg_g, avg_b;
    logic [1:0] col, row;

    assign accepted = (state == ST_IDLE) && start;
    assign abort    = (state == ST_ACCUM) && frame_start;

`ifdef FACELET_RETRY_LIMIT_EN
    logic [1:0] retry_cnt;
    logic       err_q;

    assign force_store = abort && (retry_cnt == 2'd2);
    assign err         = err_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            retry_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accepted || state == ST_STORE) retry_cnt <= '0;
            else if (abort)                    retry_cnt <= retry_cnt + 2'd1;
            if (accepted)         err_q <= 1'b0;
            else if (force_store) err_q <= 1'b1;
        end
    end
`else
    assign force_store = 1'b0;
    assign err         = 1'b0;
`endif

    // A forced store clears without reloading, so the written average is zero.
    assign acc_en    = ((state == ST_ACCUM) && !force_store) || ((state == ST_ARM) && frame_start);
    assign acc_clear = (state != ST_ACCUM) || abort;

    facelet_accum #(.WIN(WIN)) u_accum (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clear     (acc_clear),
        .en        (acc_en),
        .pix_valid (pix_valid),
        .draw_x    (DrawX),
        .draw_y    (DrawY),
        .cube_x    (CubeX),
        .cube_y    (CubeY),
        .pix_r     (Pix_R),
        .pix_g     (Pix_G),
        .pix_b     (Pix_B),
        .full      (acc_full),
        .avg_r     (avg_r),
        .avg_g     (avg_g),
        .avg_b     (avg_b)
    );

    // NOTE: default assignment first keeps this block latch-free.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (start) state_d = ST_ARM;
            ST_ARM:   if (frame_start) state_d = ST_ACCUM;
            ST_ACCUM: if (force_store || acc_full) state_d = ST_STORE;
            ST_STORE: state_d = (idx == LAST_IDX) ? ST_DONE : ST_ARM;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col = 2'(idx % 4'd3);
        row = 2'(idx / 4'd3);
    end

    assign fac_we  = (state == ST_STORE);
    assign fac_idx = idx;
    assign fac_R   = fac_we ? avg_r : 8'h00;
    assign fac_G   = fac_we ? avg_g : 8'h00;
    assign fac_B   = fac_we ? avg_b : 8'h00;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign CubeS   = 10'(WIN / 2);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            CubeX   <= 10'(GRID_X0);
            CubeY   <= 10'(GRID_Y0);
            Color_R <= '0;
            Color_G <= '0;
            Color_B <= '0;
        end else begin
            state <= state_d;
            if (accepted)                               idx <= '0;
            else if (state == ST_STORE && idx != LAST_IDX) idx <= idx + 4'd1;
            // Window centre trails idx by one cycle and is stable through ARM/ACCUM.
            CubeX <= 10'(GRID_X0) + 10'(col) * 10'(PITCH);
            CubeY <= 10'(GRID_Y0) + 10'(row) * 10'(PITCH);
            if (state == ST_STORE) begin
                Color_R <= fac_R;
                Color_G <= fac_G;
                Color_B <= fac_B;
            end
        end
    end

endmodule

// File: tb/tb_facelet_scan_ctrl.sv
// Directed self-checking bench for facelet_scan_ctrl with hand-computed expectations.
module tb_facelet_scan_ctrl;

    localparam int GRID_X0 = 220;
    localparam int GRID_Y0 = 140;
    localparam int PITCH   = 80;
    localparam int WIN     = 16;
    localparam int NPIX    = WIN * WIN;

    logic       Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, frame_start = 1'b0, pix_valid = 1'b0;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic [7:0] Pix_R = '0, Pix_G = '0, Pix_B = '0;
    logic [9:0] CubeX, CubeY, CubeS;
    logic [7:0] Color_R, Color_G, Color_B, fac_R, fac_G, fac_B;
    logic [3:0] fac_idx;
    logic       fac_we, busy, done, err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    facelet_scan_ctrl #(.GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0), .PITCH(PITCH), .WIN(WIN)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .Pix_R(Pix_R), .Pix_G(Pix_G), .Pix_B(Pix_B),
        .CubeX(CubeX), .CubeY(CubeY), .CubeS(CubeS), .Color_R(Color_R), .Color_G(Color_G), .Color_B(Color_B),
        .fac_we(fac_we), .fac_idx(fac_idx), .fac_R(fac_R), .fac_G(fac_G), .fac_B(fac_B),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [9:0] exp_cx(input int i);
        return 10'(GRID_X0 + (i % 3) * PITCH);
    endfunction

    function automatic logic [9:0] exp_cy(input int i);
        return 10'(GRID_Y0 + (i / 3) * PITCH);
    endfunction

    task automatic frame_begin();
        DrawX = '0; DrawY = '0; Pix_R = 8'hFF; Pix_G = 8'hFF; Pix_B = 8'hFF;
        pix_valid = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; pix_valid = 1'b0;
    endtask

    // Window pixels k0..k0+n-1 of facelet i; R is r_lo before pixel 'split', r_hi after.
    task automatic feed(input int i, input int k0, input int n, input logic [7:0] r_lo,
                        input logic [7:0] r_hi, input int split, input logic [7:0] g, input logic [7:0] b);
        for (int k = k0; k < k0 + n; k++) begin
            if (k % 64 == 10) begin
                Pix_R = 8'hAA; Pix_G = 8'hAA; Pix_B = 8'hAA; pix_valid = 1'b1;
                DrawX = exp_cx(i) + 10'(WIN / 2); DrawY = exp_cy(i); tick();
                DrawX = exp_cx(i); DrawY = exp_cy(i) - 10'(WIN / 2) - 10'd1; tick();
                DrawY = exp_cy(i); pix_valid = 1'b0; tick();
            end
            DrawX = exp_cx(i) - 10'(WIN / 2) + 10'(k % WIN);
            DrawY = exp_cy(i) - 10'(WIN / 2) + 10'(k / WIN);
            Pix_R = (k < split) ? r_lo : r_hi; Pix_G = g; Pix_B = b; pix_valid = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic store_checks(input string name, input int i, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b);
        chk_cnt++; if (fac_we !== 1'b1) $display("FAIL %s fac_we got %0b exp 1", name, fac_we); else pass_cnt++;
        chk_cnt++; if (fac_idx !== 4'(i)) $display("FAIL %s fac_idx got %0d exp %0d", name, fac_idx, i); else pass_cnt++;
        chk_cnt++; if ({fac_R, fac_G, fac_B} !== {r, g, b})
            $display("FAIL %s fac_rgb got %h exp %h", name, {fac_R, fac_G, fac_B}, {r, g, b}); else pass_cnt++;
        tick();
        chk_cnt++; if (fac_we !== 1'b0) $display("FAIL %s fac_we_one_cycle got %0b exp 0", name, fac_we); else pass_cnt++;
        chk_cnt++; if ({Color_R, Color_G, Color_B} !== {r, g, b})
            $display("FAIL %s color got %h exp %h", name, {Color_R, Color_G, Color_B}, {r, g, b}); else pass_cnt++;
        if (i == 8) begin
            chk_cnt++; if ({done, busy} !== 2'b11) $display("FAIL %s done_busy got %b exp 11", name, {done, busy}); else pass_cnt++;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL %s after_done got %b exp 00", name, {done, busy}); else pass_cnt++;
            tick();
            chk_cnt++; if (busy !== 1'b0) $display("FAIL %s start_with_done got busy %0b exp 0", name, busy); else pass_cnt++;
        end else begin
            chk_cnt++; if (done !== 1'b0) $display("FAIL %s early_done got %0b exp 0", name, done); else pass_cnt++;
            tick();
            chk_cnt++; if ({CubeX, CubeY} !== {exp_cx(i + 1), exp_cy(i + 1)})
                $display("FAIL %s cube_next got (%0d,%0d) exp (%0d,%0d)", name, CubeX, CubeY, exp_cx(i + 1), exp_cy(i + 1));
            else pass_cnt++;
        end
    endtask

    task automatic scan_facelet(input int i, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        frame_begin();
        feed(i, 0, NPIX - 1, r, r, 0, g, b);
        chk_cnt++; if (fac_we !== 1'b0) $display("FAIL scan%0d early_we got %0b exp 0", i, fac_we); else pass_cnt++;
        feed(i, NPIX - 1, 1, r, r, 0, g, b);
        store_checks($sformatf("scan%0d", i), i, r, g, b);
    endtask

    task automatic start_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL start busy got %0b exp 1", busy); else pass_cnt++;
        tick();
        chk_cnt++; if ({CubeX, CubeY} !== {exp_cx(0), exp_cy(0)})
            $display("FAIL start cube got (%0d,%0d) exp (%0d,%0d)", CubeX, CubeY, exp_cx(0), exp_cy(0)); else pass_cnt++;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        tick(); tick();
        chk_cnt++; if ({CubeX, CubeY, CubeS} !== {10'd220, 10'd140, 10'd8})
            $display("FAIL reset cube got (%0d,%0d,%0d) exp (220,140,8)", CubeX, CubeY, CubeS); else pass_cnt++;
        chk_cnt++; if ({fac_we, busy, done, err} !== 4'b0000)
            $display("FAIL reset flags got %b exp 0000", {fac_we, busy, done, err}); else pass_cnt++;
        chk_cnt++; if ({Color_R, Color_G, Color_B, fac_R, fac_G, fac_B, fac_idx} !== 52'h0)
            $display("FAIL reset data got %h exp 0", {Color_R, Color_G, Color_B, fac_R, fac_G, fac_B, fac_idx}); else pass_cnt++;
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_uniform_scan();
        start_scan();
        for (int i = 0; i < 9; i++) begin
            if (i == 4 || i == 8) begin
                chk_cnt++; if ({CubeX, CubeY} !== {exp_cx(i), exp_cy(i)})
                    $display("FAIL cube_idx%0d got (%0d,%0d) exp (%0d,%0d)", i, CubeX, CubeY, exp_cx(i), exp_cy(i));
                else pass_cnt++;
            end
            scan_facelet(i, 8'h40, 8'h80, 8'hC0);
        end
    endtask

    task automatic test_truncation();
        start_scan();
        frame_begin();
        feed(0, 0, NPIX, 8'h00, 8'hFF, NPIX / 2, 8'h11, 8'h22);
        store_checks("trunc", 0, 8'h7F, 8'h11, 8'h22);
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_cnt++; if ({CubeX, CubeY} !== {exp_cx(1), exp_cy(1)})
            $display("FAIL busy_start cube got (%0d,%0d) exp (%0d,%0d)", CubeX, CubeY, exp_cx(1), exp_cy(1)); else pass_cnt++;
        frame_begin();
        feed(1, 0, 100, 8'h10, 8'h10, 0, 8'h10, 8'h10);
        frame_begin();
        chk_cnt++; if ({fac_we, busy} !== 2'b01) $display("FAIL abort we_busy got %b exp 01", {fac_we, busy}); else pass_cnt++;
        feed(1, 0, NPIX - 1, 8'h33, 8'h33, 0, 8'h44, 8'h55);
        chk_cnt++; if (fac_we !== 1'b0) $display("FAIL abort early_we got %0b exp 0", fac_we); else pass_cnt++;
        feed(1, NPIX - 1, 1, 8'h33, 8'h33, 0, 8'h44, 8'h55);
        store_checks("abort", 1, 8'h33, 8'h44, 8'h55);
    endtask

    task automatic test_reset_mid();
        for (int i = 2; i < 5; i++) scan_facelet(i, 8'(i * 16), 8'h05, 8'hFA);
        frame_begin();
        feed(5, 0, 150, 8'h77, 8'h77, 0, 8'h77, 8'h77);
        Reset_n = 1'b0;
        #1;
        chk_cnt++; if ({busy, fac_we, CubeX, CubeY, Color_R} !== {2'b00, 10'd220, 10'd140, 8'h00})
            $display("FAIL mid_reset got %h exp %h", {busy, fac_we, CubeX, CubeY, Color_R}, {2'b00, 10'd220, 10'd140, 8'h00});
        else pass_cnt++;
        tick();
        Reset_n = 1'b1;
        feed(5, 150, NPIX - 150, 8'h77, 8'h77, 0, 8'h77, 8'h77);
        tick();
        chk_cnt++; if ({fac_we, busy} !== 2'b00) $display("FAIL post_reset we_busy got %b exp 00", {fac_we, busy}); else pass_cnt++;
        start_scan();
        scan_facelet(0, 8'h9C, 8'h3A, 8'h01);
    endtask

`ifdef FACELET_RETRY_LIMIT_EN
    task automatic test_retry_limit();
        start_scan();
        frame_begin();
        for (int f = 0; f < 3; f++) begin
            Pix_R = 8'h55; DrawX = 10'd5; DrawY = 10'd5; pix_valid = 1'b1;
            tick(); tick();
            pix_valid = 1'b0;
            frame_begin();
        end
        store_checks("retry", 0, 8'h00, 8'h00, 8'h00);
        chk_cnt++; if ({err, busy} !== 2'b11) $display("FAIL retry err_busy got %b exp 11", {err, busy}); else pass_cnt++;
        scan_facelet(1, 8'h21, 8'h43, 8'h65);
    endtask
`endif

    initial begin
        test_reset();
        test_uniform_scan();
        test_truncation();
        test_abort();
        test_reset_mid();
`ifdef FACELET_RETRY_LIMIT_EN
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        test_retry_limit();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
